// File: rtl/sar_pkg.sv
// Shared definitions for the DLL SAR front end: FSM encoding, search length and
// the width helper for the signed vote accumulator.
package sar_pkg;

  localparam int unsigned SarBits       = 10;
  localparam int unsigned NStepsDefault = 10;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSettle = 3'd1;
  localparam state_t StVote   = 3'd2;
  localparam state_t StDecide = 3'd3;
  localparam state_t StStep   = 3'd4;

  // Width of the signed vote seen outside the block.
  function automatic int unsigned vote_w(input int unsigned vote_len);
    return $clog2(vote_len) + 1;
  endfunction

endpackage

// File: rtl/sar_pd_voter_if.sv
// Phase-detector input / SAR-side output bundle of sar_pd_voter.
interface sar_pd_voter_if
  import sar_pkg::*;
#(
  parameter int unsigned VoteLen = 16
) ();

  localparam int unsigned VoteW = vote_w(VoteLen);

  logic                    en;
  logic                    lead;
  logic                    lag;
  logic                    comp;
  logic                    clk4;
  logic [3:0]              step_cnt;
  logic                    sar_done;
  logic signed [VoteW-1:0] vote_acc;

  modport master (
    output en, lead, lag,
    input  comp, clk4, step_cnt, sar_done, vote_acc
  );

  modport slave (
    input  en, lead, lag,
    output comp, clk4, step_cnt, sar_done, vote_acc
  );

endinterface

// File: rtl/sar_vote_acc.sv
// Signed up/down vote accumulator with synchronous clear and count enable.
// The sign/zero flags describe the value being loaded on the next edge.
module sar_vote_acc #(
  parameter int unsigned Width = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic                    dn_i,
  output logic signed [Width-1:0] acc_o,
  output logic                    neg_o,
  output logic                    zero_o
);

  logic signed [Width-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (up_i && !dn_i) begin
        acc_d = acc_q + Width'(1);
      end else if (dn_i && !up_i) begin
        acc_d = acc_q - Width'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o  = acc_q;
  assign neg_o  = acc_d[Width-1];
  assign zero_o = (acc_d == '0);

endmodule

// File: rtl/sar_pd_voter.sv
// Majority-vote filter between the bang-bang phase detector and the DLL SAR:
// settles, votes over a fixed window, registers COMP and pulses the SAR step clock.
module sar_pd_voter
  import sar_pkg::*;
#(
  parameter int unsigned VoteLen   = 16,
  parameter int unsigned SettleCyc = 8,
  parameter int unsigned NSteps    = NStepsDefault
) (
  input logic           clk,
  input logic           rst_n,
  sar_pd_voter_if.slave bus
);

  localparam int unsigned VoteW  = vote_w(VoteLen);
  // One spare bit so a unanimous lead window (+VoteLen) keeps a positive sign.
  localparam int unsigned AccW   = VoteW + 1;
  localparam int unsigned CntMax = (SettleCyc > VoteLen) ? SettleCyc : VoteLen;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic signed [AccW-1:0] AccDbgMax = AccW'(VoteLen - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            comp_q, comp_d;
  logic            clk4_q, clk4_d;
  logic [3:0]      step_q, step_d;
  logic            done_q, done_d;

  logic                   acc_clr, acc_en, acc_neg, acc_zero;
  logic signed [AccW-1:0] acc;
  logic signed [VoteW-1:0] vote_dbg;

  sar_vote_acc #(
    .Width(AccW)
  ) u_vote_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .up_i  (bus.lead),
    .dn_i  (bus.lag),
    .acc_o (acc),
    .neg_o (acc_neg),
    .zero_o(acc_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    clk4_d  = 1'b1;
    step_d  = step_q;
    acc_clr = 1'b1;
    acc_en  = 1'b0;

    if (!bus.en) begin
      state_d = StIdle;
      cnt_d   = '0;
      step_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettle;
          cnt_d   = '0;
          step_d  = '0;
        end
        StSettle: begin
          if (cnt_q == CntW'(SettleCyc - 1)) begin
            state_d = StVote;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StVote: begin
          acc_clr = 1'b0;
          acc_en  = 1'b1;
          if (cnt_q == CntW'(VoteLen - 1)) begin
            state_d = StDecide;
            cnt_d   = '0;
            // Decide on the value including this last sample; a tie keeps COMP.
            if (acc_neg) begin
              comp_d = 1'b0;
            end else if (!acc_zero) begin
              comp_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDecide: begin
          acc_clr = 1'b0;
          state_d = StStep;
          clk4_d  = 1'b0;
        end
        StStep: begin
          state_d = StSettle;
          step_d  = (step_q == 4'(NSteps)) ? step_q : step_q + 4'd1;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          step_d  = '0;
        end
      endcase
    end

    done_d = (step_d == 4'(NSteps));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      comp_q  <= 1'b1;
      clk4_q  <= 1'b1;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      clk4_q  <= clk4_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  // Debug view is one bit narrower; only the unanimous-lead count needs clamping.
  always_comb begin
    vote_dbg = acc[VoteW-1:0];
    if (acc > AccDbgMax) begin
      vote_dbg = AccDbgMax[VoteW-1:0];
    end
  end

  assign bus.comp     = comp_q;
  assign bus.clk4     = clk4_q;
  assign bus.step_cnt = step_q;
  assign bus.sar_done = done_q;
  assign bus.vote_acc = vote_dbg;

endmodule

// File: tb/tb_sar_pd_voter.sv
// Randomized bench for sar_pd_voter against a position-in-period reference model.
module tb_sar_pd_voter;

  localparam int VoteLen   = 16;
  localparam int SettleCyc = 8;
  localparam int NSteps    = 10;
  localparam int Period    = SettleCyc + VoteLen + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sar_pd_voter_if #(.VoteLen(VoteLen)) bus ();

  sar_pd_voter #(
    .VoteLen  (VoteLen),
    .SettleCyc(SettleCyc),
    .NSteps   (NSteps)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: t counts cycles since SETTLE entry, sum is the current window's vote.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_sum    = 0;
  bit m_comp   = 1'b1;
  int m_step   = 0;
  int mode     = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_pos();
    return m_active ? (m_t % Period) : 0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_sum    = 0;
    m_comp   = 1'b1;
    m_step   = 0;
  endtask

  task automatic model_edge();
    int p;
    if (!bus.en) begin
      m_active = 1'b0;
      m_sum    = 0;
      m_step   = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
      m_sum    = 0;
    end else begin
      p = m_t % Period;
      if (p >= SettleCyc && p < SettleCyc + VoteLen) begin
        if (bus.lead && !bus.lag) m_sum++;
        if (bus.lag && !bus.lead) m_sum--;
        if (p == SettleCyc + VoteLen - 1) begin
          if (m_sum > 0) m_comp = 1'b1;
          else if (m_sum < 0) m_comp = 1'b0;
        end
      end
      if (p == Period - 1) begin
        if (m_step < NSteps) m_step++;
        m_sum = 0;
      end
      m_t++;
    end
  endtask

  task automatic check_outputs();
    int exp_acc;
    int got_acc;
    int p;
    p       = cur_pos();
    exp_acc = (m_sum > VoteLen - 1) ? VoteLen - 1 : m_sum;
    got_acc = bus.vote_acc;
    check_eq("clk4", int'(bus.clk4), (m_active && p == Period - 1) ? 0 : 1);
    check_eq("comp", int'(bus.comp), int'(m_comp));
    check_eq("step_cnt", int'(bus.step_cnt), m_step);
    check_eq("sar_done", int'(bus.sar_done), (m_step == NSteps) ? 1 : 0);
    check_eq("vote_acc", got_acc, exp_acc);
    if (mode == 2 && m_active && p == SettleCyc + VoteLen) begin
      check_eq("acc_lag_window", got_acc, -4);
      check_eq("comp_lag_window", int'(bus.comp), 0);
    end
  endtask

  task automatic drive_inputs();
    int w;
    w = cur_pos() - SettleCyc;
    case (mode)
      1: begin bus.lead = 1'b1; bus.lag = 1'b0; end
      2: begin bus.lag = (w < 10); bus.lead = !(w < 10); end
      3: begin bus.lead = (w < 8); bus.lag = !(w < 8); end
      4: begin bus.lead = 1'b1; bus.lag = 1'b1; end
      default: begin
        bus.lead = 1'($urandom_range(0, 1));
        bus.lag  = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic cycle();
    drive_inputs();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  // Called from IDLE with en already high: clk4 must be low in the Period-th cycle
  // counting the first SETTLE cycle as cycle 1.
  task automatic measure_first_fall(input string tag);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 3 * Period) begin
      cycle();
      k++;
      if (bus.clk4 == 1'b0) seen = 1'b1;
    end
    check_eq(tag, seen ? k : -1, 26);
  endtask

  task automatic run_to_pos(input int pos, input string tag);
    int k;
    k = 0;
    while (!(m_active && cur_pos() == pos) && k < 4 * Period) begin
      cycle();
      k++;
    end
    check_eq(tag, (m_active && cur_pos() == pos) ? 1 : 0, 1);
  endtask

  initial begin
    int lows;
    bus.en   = 1'b0;
    bus.lead = 1'b0;
    bus.lag  = 1'b0;
    model_reset();

    #12;
    check_eq("rst_comp", int'(bus.comp), 1);
    check_eq("rst_clk4", int'(bus.clk4), 1);
    check_eq("rst_step", int'(bus.step_cnt), 0);
    check_eq("rst_done", int'(bus.sar_done), 0);
    check_eq("rst_acc", int'(bus.vote_acc), 0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // First window all ties: comp keeps its reset value.
    mode   = 4;
    bus.en = 1'b1;
    measure_first_fall("first_fall");
    check_eq("comp_tie_hold", int'(bus.comp), 1);

    mode = 1;
    repeat (Period) cycle();
    mode = 2;
    repeat (Period) cycle();
    mode = 3;
    repeat (Period) cycle();
    check_eq("comp_balanced_hold", int'(bus.comp), 0);

    mode = 0;
    repeat (8 * Period) cycle();
    check_eq("sat_step", int'(bus.step_cnt), NSteps);
    check_eq("sat_done", int'(bus.sar_done), 1);

    // Drop en while clk4 is low.
    run_to_pos(Period - 1, "reach_step");
    bus.en = 1'b0;
    cycle();
    check_eq("drop_clk4", int'(bus.clk4), 1);
    check_eq("drop_step", int'(bus.step_cnt), 0);
    lows = 0;
    repeat (40) begin
      cycle();
      if (bus.clk4 == 1'b0) lows++;
    end
    check_eq("idle_falls", lows, 0);
    bus.en = 1'b1;
    measure_first_fall("refall_en");

    // Random en toggling.
    repeat (400) begin
      if ($urandom_range(0, 63) == 0) bus.en = !bus.en;
      cycle();
    end

    // Asynchronous reset in the middle of a vote window.
    bus.en = 1'b1;
    run_to_pos(SettleCyc + 5, "reach_vote");
    rst_n = 1'b0;
    #1;
    check_eq("arst_comp", int'(bus.comp), 1);
    check_eq("arst_clk4", int'(bus.clk4), 1);
    check_eq("arst_step", int'(bus.step_cnt), 0);
    check_eq("arst_done", int'(bus.sar_done), 0);
    check_eq("arst_acc", int'(bus.vote_acc), 0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    measure_first_fall("refall_rst");
    repeat (3 * Period) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
